// File: rtl/mem_dump_unit.sv
// Streams DEPTH consecutive memory words from START_ADDR over a valid/ready port.
// Define MEM_DUMP_CHECKSUM_EN to append a WIDTH-bit running-sum beat after the data.
module mem_dump_unit #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int START_ADDR   = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             start,
    output logic [WIDTH-1:0] mem_addr_bus,
    output logic             mem_rd_en,
    input  logic [WIDTH-1:0] mem_read_bus,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic             dump_last,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
`ifdef MEM_DUMP_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic             mem_rd_en_q, mem_rd_en_d;
    logic [WIDTH-1:0] dump_data_q, dump_data_d;
    logic             dump_valid_q, dump_valid_d;
    logic             dump_last_q, dump_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_word;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             csum_beat_q, csum_beat_d;
`endif

    assign last_word = (cnt_q == CW'(DEPTH - 1));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_en_d  = 1'b0;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        dump_last_d  = dump_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
        sum_d        = sum_q;
        csum_beat_d  = csum_beat_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = READ;
                    addr_d      = WIDTH'(START_ADDR);
                    mem_addr_d  = WIDTH'(START_ADDR);
                    cnt_d       = '0;
                    mem_rd_en_d = 1'b1;
                    busy_d      = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum_d       = '0;
                    csum_beat_d = 1'b0;
`endif
                end
            end
            READ: begin
                state_d = WAIT;
                lat_d   = LW'(READ_LATENCY - 1);
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d      = SEND;
                    dump_data_d  = mem_read_bus;
                    dump_valid_d = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    dump_last_d  = 1'b0;
`else
                    dump_last_d  = last_word;
`endif
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            SEND: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                    if (csum_beat_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sum_d = sum_q + dump_data_q;
                        if (last_word) begin
                            state_d = CSUM;
                        end else begin
                            state_d     = READ;
                            cnt_d       = cnt_q + 1'b1;
                            addr_d      = addr_q + 1'b1;
                            mem_addr_d  = addr_q + 1'b1;
                            mem_rd_en_d = 1'b1;
                        end
                    end
`else
                    if (last_word) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = READ;
                        cnt_d       = cnt_q + 1'b1;
                        addr_d      = addr_q + 1'b1;
                        mem_addr_d  = addr_q + 1'b1;
                        mem_rd_en_d = 1'b1;
                    end
`endif
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            // sum_q already includes the final data word here
            CSUM: begin
                state_d      = SEND;
                dump_data_d  = sum_q;
                dump_valid_d = 1'b1;
                dump_last_d  = 1'b1;
                csum_beat_d  = 1'b1;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= IDLE;
            addr_q       <= WIDTH'(START_ADDR);
            cnt_q        <= '0;
            lat_q        <= '0;
            mem_addr_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_q        <= '0;
            csum_beat_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_en_q  <= mem_rd_en_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_q        <= sum_d;
            csum_beat_q  <= csum_beat_d;
`endif
        end
    end

    assign mem_addr_bus = mem_addr_q;
    assign mem_rd_en    = mem_rd_en_q;
    assign dump_data    = dump_data_q;
    assign dump_valid   = dump_valid_q;
    assign dump_last    = dump_last_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
